// File: rtl/hpdmc_wrseq_pkg.sv
// rtl/hpdmc_wrseq_pkg.sv - shared DDR16 write-path constants and burst length encoding
package hpdmc_wrseq_pkg;

    // Burst length as programmed in the SDRAM mode register
    typedef enum logic [1:0] {
        BL2 = 2'd0,
        BL4 = 2'd1,
        BL8 = 2'd2
    } burst_len_e;

    localparam int DEFAULT_DQ_WIDTH = 16;

    // DQS level driven during the preamble and postamble cycles
    localparam logic DQS_PRE_LEVEL  = 1'b0;
    localparam logic DQS_POST_LEVEL = 1'b0;

    // Width of the command spacing counter; holds up to BURST_CYCLES-1 = 3
    localparam int SPACE_W = 3;

    // Controller clock cycles occupied by one DDR burst
    function automatic int burst_cycles(input burst_len_e bl);
        case (bl)
            BL2:     return 1;
            BL4:     return 2;
            default: return 4;
        endcase
    endfunction

endpackage

// File: rtl/hpdmc_wrseq_if.sv
// rtl/hpdmc_wrseq_if.sv - write command and write data handshake into the sequencer
interface hpdmc_wrseq_if
    import hpdmc_wrseq_pkg::*;
#(
    parameter int DQ_WIDTH = DEFAULT_DQ_WIDTH
) ();
    localparam int NL = DQ_WIDTH / 8;

    logic                  wr_cmd;
    logic                  wr_ready;
    logic [2*DQ_WIDTH-1:0] wdata;
    logic [2*NL-1:0]       wmask;
    logic                  wdata_valid;
    logic                  wdata_ack;

    // Scheduler / data source side
    modport master (
        output wr_cmd, wdata, wmask, wdata_valid,
        input  wr_ready, wdata_ack
    );

    // Sequencer side
    modport slave (
        input  wr_cmd, wdata, wmask, wdata_valid,
        output wr_ready, wdata_ack
    );

endinterface

// File: rtl/hpdmc_wrseq_pipe.sv
// rtl/hpdmc_wrseq_pipe.sv - write marker shift register and command spacing counter
module hpdmc_wrseq_pipe
    import hpdmc_wrseq_pkg::*;
#(
    parameter int BURST_CYCLES = 2,
    parameter int WL           = 1
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic accept,
    output logic wr_ready,
    output logic empty,
    output logic pre_nxt,
    output logic data_nxt,
    output logic post_nxt,
    output logic ack
);
    localparam int DEPTH = WL + BURST_CYCLES + 1;
    localparam logic [DEPTH-1:0] BURST_ONES = DEPTH'((1 << BURST_CYCLES) - 1);
    // mark_q[k] set means a command was accepted k edges before the current cycle.
    // Each window looks one edge further ahead than the output cycle it feeds.
    localparam logic [DEPTH-1:0] WIN_AHEAD = BURST_ONES << (WL - 1);
    localparam logic [DEPTH-1:0] WIN_NXT   = BURST_ONES << WL;
    localparam logic [DEPTH-1:0] WIN_NOW   = BURST_ONES << (WL + 1);

    logic [DEPTH-1:0]   mark_q, mark_d;
    logic [SPACE_W-1:0] space_q, space_d;
    logic               data_ahead, data_now;

    assign data_ahead = |(mark_q & WIN_AHEAD);
    assign data_nxt   = |(mark_q & WIN_NXT);
    assign data_now   = |(mark_q & WIN_NOW);
    assign pre_nxt    = data_ahead & ~data_nxt;
    assign post_nxt   = data_now & ~data_nxt;
    assign ack        = data_nxt;
    assign wr_ready   = (space_q == '0);
    assign empty      = ~|mark_q;

    // Advance the markers every cycle and hold off new commands for one burst
    always_comb begin
        mark_d  = {mark_q[DEPTH-2:0], accept};
        space_d = space_q;
        if (accept) begin
            space_d = SPACE_W'(BURST_CYCLES - 1);
        end else if (space_q != '0) begin
            space_d = space_q - SPACE_W'(1);
        end
    end

    // Marker and spacing state
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            mark_q  <= '0;
            space_q <= '0;
        end else begin
            mark_q  <= mark_d;
            space_q <= space_d;
        end
    end

endmodule

// File: rtl/hpdmc_wrseq.sv
// rtl/hpdmc_wrseq.sv - DDR16 write-burst sequencer driving DQ/DM/DQS output register pairs
module hpdmc_wrseq
    import hpdmc_wrseq_pkg::*;
#(
    parameter int DQ_WIDTH     = DEFAULT_DQ_WIDTH,
    parameter int BURST_CYCLES = burst_cycles(BL4),
    parameter int WL           = 1
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    hpdmc_wrseq_if.slave          wr_if,
    output logic [DQ_WIDTH-1:0]   dq_d0,
    output logic [DQ_WIDTH-1:0]   dq_d1,
    output logic [DQ_WIDTH/8-1:0] dm_d0,
    output logic [DQ_WIDTH/8-1:0] dm_d1,
    output logic [DQ_WIDTH/8-1:0] dqs_d0,
    output logic [DQ_WIDTH/8-1:0] dqs_d1,
    output logic                  dq_oe,
    output logic                  dqs_oe,
    output logic                  wr_underrun,
    output logic                  idle
);
    localparam int NL = DQ_WIDTH / 8;

    logic ready, empty, pre_nxt, data_nxt, post_nxt, ack, accept;

    logic [DQ_WIDTH-1:0] dq_d0_q, dq_d0_d, dq_d1_q, dq_d1_d;
    logic [NL-1:0]       dm_d0_q, dm_d0_d, dm_d1_q, dm_d1_d;
    logic [NL-1:0]       dqs_d0_q, dqs_d0_d, dqs_d1_q, dqs_d1_d;
    logic                dq_oe_q, dq_oe_d, dqs_oe_q, dqs_oe_d;
    logic                underrun_q, underrun_d;

    assign accept          = wr_if.wr_cmd & ready;
    assign wr_if.wr_ready  = ready;
    assign wr_if.wdata_ack = ack;

    hpdmc_wrseq_pipe #(
        .BURST_CYCLES (BURST_CYCLES),
        .WL           (WL)
    ) u_pipe (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .accept    (accept),
        .wr_ready  (ready),
        .empty     (empty),
        .pre_nxt   (pre_nxt),
        .data_nxt  (data_nxt),
        .post_nxt  (post_nxt),
        .ack       (ack)
    );

    // Next pin values: data beats in data cycles, DQS framing around them, masks released otherwise
    always_comb begin
        dq_d0_d  = dq_d0_q;
        dq_d1_d  = dq_d1_q;
        dm_d0_d  = '1;
        dm_d1_d  = '1;
        dqs_d0_d = '0;
        dqs_d1_d = '0;
        if (data_nxt) begin
            dq_d0_d  = wr_if.wdata[DQ_WIDTH-1:0];
            dq_d1_d  = wr_if.wdata[2*DQ_WIDTH-1:DQ_WIDTH];
            dm_d0_d  = wr_if.wmask[NL-1:0];
            dm_d1_d  = wr_if.wmask[2*NL-1:NL];
            dqs_d0_d = '1;
        end else if (pre_nxt) begin
            dqs_d0_d = {NL{DQS_PRE_LEVEL}};
            dqs_d1_d = {NL{DQS_PRE_LEVEL}};
        end else if (post_nxt) begin
            dqs_d0_d = {NL{DQS_POST_LEVEL}};
            dqs_d1_d = {NL{DQS_POST_LEVEL}};
        end
        dq_oe_d    = data_nxt;
        dqs_oe_d   = pre_nxt | data_nxt | post_nxt;
        underrun_d = underrun_q | (ack & ~wr_if.wdata_valid);
    end

    // Output register stage; reset parks the pins undriven with all bytes masked
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            dq_d0_q    <= '0;
            dq_d1_q    <= '0;
            dm_d0_q    <= '1;
            dm_d1_q    <= '1;
            dqs_d0_q   <= '0;
            dqs_d1_q   <= '0;
            dq_oe_q    <= 1'b0;
            dqs_oe_q   <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            dq_d0_q    <= dq_d0_d;
            dq_d1_q    <= dq_d1_d;
            dm_d0_q    <= dm_d0_d;
            dm_d1_q    <= dm_d1_d;
            dqs_d0_q   <= dqs_d0_d;
            dqs_d1_q   <= dqs_d1_d;
            dq_oe_q    <= dq_oe_d;
            dqs_oe_q   <= dqs_oe_d;
            underrun_q <= underrun_d;
        end
    end

    assign dq_d0       = dq_d0_q;
    assign dq_d1       = dq_d1_q;
    assign dm_d0       = dm_d0_q;
    assign dm_d1       = dm_d1_q;
    assign dqs_d0      = dqs_d0_q;
    assign dqs_d1      = dqs_d1_q;
    assign dq_oe       = dq_oe_q;
    assign dqs_oe      = dqs_oe_q;
    assign wr_underrun = underrun_q;
    assign idle        = empty & ~dqs_oe_q & ready;

endmodule

// File: tb/tb_hpdmc_wrseq.sv
// tb/tb_hpdmc_wrseq.sv - randomized scoreboard bench for hpdmc_wrseq
module tb_hpdmc_wrseq;
    localparam int DQ_WIDTH = 16;
    localparam int NL       = DQ_WIDTH / 8;
    localparam int BC       = 2;
    localparam int WL       = 1;
    localparam int MAXC     = 2400;

    typedef struct {
        logic [2*DQ_WIDTH-1:0] dq;
        logic [2*NL-1:0]       dm;
    } beat_t;

    logic                sys_clk   = 1'b0;
    logic                sys_rst_n = 1'b0;
    logic [DQ_WIDTH-1:0] dq_d0, dq_d1;
    logic [NL-1:0]       dm_d0, dm_d1, dqs_d0, dqs_d1;
    logic                dq_oe, dqs_oe, wr_underrun, idle;

    hpdmc_wrseq_if #(.DQ_WIDTH(DQ_WIDTH)) wr_if ();

    hpdmc_wrseq #(
        .DQ_WIDTH     (DQ_WIDTH),
        .BURST_CYCLES (BC),
        .WL           (WL)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .wr_if       (wr_if),
        .dq_d0       (dq_d0),
        .dq_d1       (dq_d1),
        .dm_d0       (dm_d0),
        .dm_d1       (dm_d1),
        .dqs_d0      (dqs_d0),
        .dqs_d1      (dqs_d1),
        .dq_oe       (dq_oe),
        .dqs_oe      (dqs_oe),
        .wr_underrun (wr_underrun),
        .idle        (idle)
    );

    always #5 sys_clk = ~sys_clk;

    // Reference model, indexed by edge number since the last reset release
    bit                    acc_c  [MAXC];
    bit                    ack_c  [MAXC];
    bit                    data_c [MAXC];
    bit                    cmd_at [MAXC];
    int                    cyc;
    int                    under_from;
    bit                    mon_en = 1'b0;
    beat_t                 exp_q[$];
    logic [2*DQ_WIDTH-1:0] last_dq;
    int                    total = 0;
    int                    bad   = 0;
    int                    c0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 40)
                $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
        end
    endtask

    function automatic bit acc_within(input int n, input int span);
        for (int k = 0; k < span; k++)
            if (n - k >= 0 && acc_c[n-k]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < MAXC; i++) begin
            acc_c[i] = 0; ack_c[i] = 0; data_c[i] = 0; cmd_at[i] = 0;
        end
        cyc        = 0;
        under_from = MAXC * 4;
        exp_q.delete();
        last_dq    = '0;
    endtask

    task automatic set_idle_inputs();
        wr_if.wr_cmd      = 1'b0;
        wr_if.wdata       = '0;
        wr_if.wmask       = '0;
        wr_if.wdata_valid = 1'b1;
    endtask

    task automatic release_reset();
        @(negedge sys_clk);
        set_idle_inputs();
        sys_rst_n = 1'b1;
        model_reset();
        #1 mon_en = 1'b1;
    endtask

    // One clock: choose inputs for the next edge and record what the spec says they cause
    task automatic drive_cycle(input int prob, input bit under_en);
        int                    n;
        bit                    cmd, vld;
        logic [2*DQ_WIDTH-1:0] wd;
        logic [2*NL-1:0]       wm;
        @(posedge sys_clk);
        cyc++;
        #1;
        n = cyc;
        if (prob < 0) cmd = cmd_at[n+1];
        else          cmd = (int'($urandom_range(99)) < prob);
        if (cmd && !acc_within(n, BC - 1)) begin
            acc_c[n+1] = 1'b1;
            for (int i = 0; i < BC; i++) begin
                ack_c[n+1+WL+i]  = 1'b1;
                data_c[n+2+WL+i] = 1'b1;
            end
        end
        wd = (2*DQ_WIDTH)'($urandom);
        wm = (2*NL)'($urandom);
        if (ack_c[n]) begin
            vld = under_en ? ($urandom_range(7) != 0) : 1'b1;
            exp_q.push_back('{dq: wd, dm: wm});
            if (!vld && under_from > n + 1) under_from = n + 1;
        end else begin
            vld = ($urandom_range(1) == 1);
        end
        wr_if.wr_cmd      = cmd;
        wr_if.wdata       = wd;
        wr_if.wmask       = wm;
        wr_if.wdata_valid = vld;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_dq_oe"},   dq_oe, 1'b0);
        chk({tag, "_dqs_oe"},  dqs_oe, 1'b0);
        chk({tag, "_dq"},      {dq_d1, dq_d0}, '0);
        chk({tag, "_dm"},      {dm_d1, dm_d0}, {(2*NL){1'b1}});
        chk({tag, "_dqs"},     {dqs_d1, dqs_d0}, '0);
        chk({tag, "_underrun"}, wr_underrun, 1'b0);
        chk({tag, "_ack"},     wr_if.wdata_ack, 1'b0);
        chk({tag, "_ready"},   wr_if.wr_ready, 1'b1);
        chk({tag, "_idle"},    idle, 1'b1);
    endtask

    // Monitor: per-cycle pin timing against the model, data beats against the scoreboard queue
    always @(negedge sys_clk) begin
        if (mon_en) begin
            int    n;
            bit    dn, dp, dx, rdy;
            beat_t e;
            n   = cyc;
            dn  = data_c[n];
            dp  = (n > 0) ? data_c[n-1] : 1'b0;
            dx  = data_c[n+1];
            rdy = !acc_within(n, BC - 1);
            chk("dq_oe", dq_oe, dn);
            chk("dqs_oe", dqs_oe, dp | dn | dx);
            chk("dqs_d0", dqs_d0, {NL{dn}});
            chk("dqs_d1", dqs_d1, '0);
            chk("wdata_ack", wr_if.wdata_ack, ack_c[n]);
            chk("wr_ready", wr_if.wr_ready, rdy);
            chk("idle", idle, !acc_within(n, WL + BC + 1) && !(dp | dn | dx) && rdy);
            chk("wr_underrun", wr_underrun, n >= under_from);
            if (dq_oe === 1'b1) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_underflow cyc=%0d got=beat want=none", n);
                end else begin
                    e       = exp_q.pop_front();
                    last_dq = e.dq;
                    chk("dq_beat", {dq_d1, dq_d0}, e.dq);
                    chk("dm_beat", {dm_d1, dm_d0}, e.dm);
                end
            end else begin
                chk("dq_hold", {dq_d1, dq_d0}, last_dq);
                chk("dm_idle", {dm_d1, dm_d0}, {(2*NL){1'b1}});
            end
        end
    end

    initial begin
        model_reset();
        set_idle_inputs();
        sys_rst_n = 1'b0;
        repeat (3) @(posedge sys_clk);
        #2 chk_reset_state("por");
        release_reset();

        // Directed spacing: single, gap 0, gap 1, gap 2, gap 3, then wr_cmd held high
        cmd_at[10] = 1; cmd_at[20] = 1; cmd_at[22] = 1; cmd_at[30] = 1; cmd_at[33] = 1;
        cmd_at[40] = 1; cmd_at[44] = 1; cmd_at[50] = 1; cmd_at[55] = 1;
        for (int i = 70; i < 78; i++) cmd_at[i] = 1;
        repeat (100) drive_cycle(-1, 1'b0);

        repeat (200) drive_cycle(100, 1'b0);
        repeat (300) drive_cycle(50, 1'b0);
        repeat (300) drive_cycle(25, 1'b0);
        repeat (300) drive_cycle(10, 1'b0);
        repeat (12) drive_cycle(0, 1'b0);
        chk("sb_drained_a", exp_q.size(), 0);

        // Data source starvation; the flag must stick until reset
        repeat (400) drive_cycle(50, 1'b1);
        repeat (12) drive_cycle(0, 1'b1);

        // Reset asserted inside the first data cycle of a burst
        c0 = cyc + 3;
        cmd_at[c0] = 1;
        while (cyc < c0 + WL + 1) drive_cycle(-1, 1'b1);
        mon_en = 1'b0;
        chk("pre_reset_dq_oe", dq_oe, 1'b1);
        chk("pre_reset_underrun", wr_underrun, under_from <= cyc);
        #1 sys_rst_n = 1'b0;
        #1 chk_reset_state("mid");
        repeat (2) @(posedge sys_clk);
        #2 chk_reset_state("held");
        release_reset();

        repeat (300) drive_cycle(40, 1'b0);
        repeat (12) drive_cycle(0, 1'b0);
        chk("sb_drained_c", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hpdmc_wrseq.md
Name: hpdmc_wrseq

Overview:
- Write-burst sequencer for the DDR16 SDRAM controller's output datapath.
- Accepts write commands from the command scheduler, fetches write data and masks from the data source, and drives the D0/D1 and output-enable inputs of the DQ, DM and DQS DDR output register pairs.
- Places each data burst WL cycles after its command and generates DQS preamble and postamble.
- Merges back-to-back bursts seamlessly.

Parameters:
- DQ_WIDTH, 16: DQ pin count; must be a multiple of 8. NL = DQ_WIDTH/8 byte lanes.
- BURST_CYCLES, 2: clock cycles per burst (BL4 on DDR = 2); range 1..4.
- WL, 1: clock cycles from command edge to preamble cycle; range 1..4.

Ports:
- sys_clk  in  1  controller clock; all DDR output register pairs are clocked from it or from phase-shifted copies.
- sys_rst_n  in  1  asynchronous, active-low reset.
- wr_cmd  in  1  write command issued this cycle; accepted when wr_cmd & wr_ready at a rising edge.
- wr_ready  out  1  sequencer can accept a write command this cycle.
- wdata  in  2*DQ_WIDTH  [DQ_WIDTH-1:0] = rising beat, upper half = falling beat.
- wmask  in  2*NL  byte masks, same split as wdata; 1 = masked.
- wdata_valid  in  1  source has wdata/wmask valid.
- wdata_ack  out  1  wdata/wmask sampled at the next edge.
- dq_d0, dq_d1  out  DQ_WIDTH  to DQ output register pairs.
- dm_d0, dm_d1  out  NL  to DM output register pairs.
- dqs_d0, dqs_d1  out  NL  to DQS output register pairs.
- dq_oe  out  1  DQ/DM drive enable, active high.
- dqs_oe  out  1  DQS drive enable, active high.
- wr_underrun  out  1  sticky error flag.
- idle  out  1  no write in flight and pins released.

Behaviour:
- All outputs except wr_ready, wdata_ack and idle are registered on sys_clk.
- sys_rst_n low, asynchronous and at any time including mid-burst, forces:
  - dq_oe = dqs_oe = 0; all d0/d1 = 0; dm_d0/dm_d1 = all-ones.
  - wr_underrun = 0; pipeline and spacing counter cleared.
  - Result after reset: wr_ready = 1, idle = 1, wdata_ack = 0.
- Command accepted at edge E. Cycle "after edge E+k" means output values following that edge.
  - After E+WL: preamble cycle. dqs_oe=1, dqs_d0=dqs_d1=0, dq_oe=0.
  - After E+WL+1 .. E+WL+BURST_CYCLES: data cycles. dq_oe=1, dqs_oe=1, dqs_d0=all-ones, dqs_d1=0. dq_d0/dq_d1/dm_d0/dm_d1 = wdata/wmask halves sampled at that edge.
  - After E+WL+BURST_CYCLES+1: postamble cycle. dqs_oe=1, dqs=0, dq_oe=0.
- DQS 90-degree phase placement is the clocking of the DQS register pairs, not this block's job.
- wdata_ack is combinational from pipeline state. It is high in the cycles after edges E+WL .. E+WL+BURST_CYCLES-1, exactly BURST_CYCLES cycles per command.
- Underrun: wdata_ack & ~wdata_valid at an edge sets wr_underrun; it clears only on reset. The data is still sampled and the burst continues unchanged.
- Outside data cycles: dq_d0/dq_d1 hold their last value; dm_d0/dm_d1 = all-ones.
- Command spacing: after an acceptance, wr_ready is low for BURST_CYCLES-1 cycles. Minimum command-to-command distance is therefore BURST_CYCLES. wr_cmd while wr_ready=0 is ignored.
- Overlap rules, with gap = command distance minus BURST_CYCLES:
  - gap 0: data cycles are contiguous; no pre/postamble between bursts.
  - gap 1: the single idle cycle is both postamble and preamble. dqs_oe stays 1, dqs=0, dq_oe=0.
  - gap 2: postamble then preamble, dqs_oe held 1 throughout.
  - gap >= 3: dqs_oe falls after the postamble and rises again at the next preamble.
- Implementation: a marker shift register of depth WL+BURST_CYCLES+1, shifted each cycle and loaded on acceptance. data_phase(t) = OR of the BURST_CYCLES markers in the data window. dqs_oe = data_phase(t-1) | data_phase(t) | data_phase(t+1); data_phase(t+1) is known because WL >= 1.
- idle = shift register empty & dqs_oe=0 & spacing counter zero.

Decomposition:
- Shared controller constants header: burst length encoding, DQS preamble/postamble values, default DQ_WIDTH.
- One natural sub-module: hpdmc_wrseq_pipe, the marker shift register plus spacing counter. It outputs pre/data/post/ack flags. The top level holds the data/mask/DQS output registers and the underrun flag.

Test Plan:
- Single write (WL=1, BC=2), cmd at edge 10, wdata=0xBEEF_1234 then 0xCAFE_5678, wmask=0 -> preamble after edge 11. Data after edges 12 and 13: dq_d0=0x1234/dq_d1=0xBEEF, then 0x5678/0xCAFE; dm=0. Postamble after edge 14; dqs_oe=0 and idle=1 after edge 15; wdata_ack high in the cycles after edges 11 and 12 only.
- Seamless: cmds at edges 10 and 12 -> dq_oe high continuously after edges 12..15. Exactly one preamble (after 11) and one postamble (after 16); 4 acks.
- Gap 1 and gap 3: cmds at 10/13 -> dqs_oe high continuously after edges 11..17, dq_oe low only after edge 14. Cmds at 10/15 -> dqs_oe low after edge 15, high again after edge 16.
- Spacing: wr_cmd held high from edge 10 with BC=2 -> acceptances only at edges 10, 12, 14; wr_ready=0 in the cycles after edges 10, 12, 14.
- Underrun: wdata_valid=0 during the second ack cycle -> wr_underrun=1 after the next edge; burst timing unchanged; flag persists until sys_rst_n falls.
- Reset mid-burst: sys_rst_n low during the first data cycle -> dq_oe=dqs_oe=0 and dm=all-ones immediately without waiting for a clock edge. After release: idle=1, wr_ready=1, and no residual ack.
